// File: rtl/alu_pkg.sv
// Shared types for the pipelined execute ALU: op codes, jXX/cmovXX
// condition codes and the architectural condition-code register.
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_XOR = 2'b11
    } alu_op_e;

    typedef enum logic [2:0] {
        C_ALWAYS = 3'd0,
        C_LE     = 3'd1,
        C_L      = 3'd2,
        C_E      = 3'd3,
        C_NE     = 3'd4,
        C_GE     = 3'd5,
        C_G      = 3'd6,
        C_RSVD   = 3'd7
    } cond_e;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

    function automatic logic cond_eval(input cc_t cc, input logic [2:0] fn);
        logic w_lt;
        logic w_res;
        w_lt  = cc.sf ^ cc.of;
        w_res = 1'b0;
        case (cond_e'(fn))
            C_ALWAYS: w_res = 1'b1;
            C_LE:     w_res = w_lt | cc.zf;
            C_L:      w_res = w_lt;
            C_E:      w_res = cc.zf;
            C_NE:     w_res = !cc.zf;
            C_GE:     w_res = !w_lt;
            C_G:      w_res = !w_lt && !cc.zf;
            default:  w_res = 1'b0;
        endcase
        return w_res;
    endfunction

endpackage

// File: rtl/alu_cc_pipe_core.sv
// Combinational WIDTH-bit ALU: add, sub, and, xor with ZF/SF/OF.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_res,
    output logic             o_zf,
    output logic             o_sf,
    output logic             o_of
);

    logic [WIDTH-1:0] w_res;
    logic             w_of;

    always_comb begin
        w_res = '0;
        w_of  = 1'b0;
        case (alu_op_e'(i_op))
            ALU_ADD: begin
                w_res = i_a + i_b;
                w_of  = (i_a[WIDTH-1] == i_b[WIDTH-1])
                     && (w_res[WIDTH-1] != i_a[WIDTH-1]);
            end
            ALU_SUB: begin
                w_res = i_a - i_b;
                w_of  = (i_a[WIDTH-1] != i_b[WIDTH-1])
                     && (w_res[WIDTH-1] != i_a[WIDTH-1]);
            end
            ALU_AND: w_res = i_a & i_b;
            ALU_XOR: w_res = i_a ^ i_b;
            default: w_res = '0;
        endcase
    end

    assign o_res = w_res;
    assign o_zf  = (w_res == '0);
    assign o_sf  = w_res[WIDTH-1];
    assign o_of  = w_of;

endmodule

// File: rtl/alu_cc_pipe.sv
// Execute-stage ALU: STAGES-deep valid/ready pipeline, CC register
// updated on retire, and jXX/cmovXX condition evaluation.
module alu_cc_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int STAGES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_set_cc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zf,
    output logic             out_sf,
    output logic             out_of,
    output logic             cc_zf,
    output logic             cc_sf,
    output logic             cc_of,
    input  logic [2:0]       cond_fn,
    output logic             cnd
);

    logic [STAGES-1:0] r_vld;
    logic [STAGES-1:0] r_set;
    logic [WIDTH-1:0]  r_res [STAGES];
    cc_t               r_flg [STAGES];
    cc_t               r_cc;

    logic [STAGES-1:0] w_adv;
    logic [WIDTH-1:0]  w_res;
    logic              w_zf;
    logic              w_sf;
    logic              w_of;
    logic              w_acc;
    logic              w_retire;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .i_op  (in_op),
        .i_a   (in_a),
        .i_b   (in_b),
        .o_res (w_res),
        .o_zf  (w_zf),
        .o_sf  (w_sf),
        .o_of  (w_of)
    );

    // Stage i can load when it, or any stage after it, has a hole,
    // or when the head is being taken this cycle.
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            w_adv[i] = out_ready;
            for (int j = i; j < STAGES; j++) begin
                if (!r_vld[j]) begin
                    w_adv[i] = 1'b1;
                end
            end
        end
    end

    assign in_ready = !flush && w_adv[0];
    assign w_acc    = in_valid && in_ready;
    assign w_retire = r_vld[STAGES-1] && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            r_set <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_res[i] <= '0;
                r_flg[i] <= '0;
            end
        end else begin
            if (w_adv[0]) begin
                r_vld[0] <= w_acc;
                if (w_acc) begin
                    r_set[0] <= in_set_cc;
                    r_res[0] <= w_res;
                    r_flg[0] <= '{zf: w_zf, sf: w_sf, of: w_of};
                end
            end
            for (int i = 1; i < STAGES; i++) begin
                if (w_adv[i]) begin
                    r_vld[i] <= r_vld[i-1];
                    if (r_vld[i-1]) begin
                        r_set[i] <= r_set[i-1];
                        r_res[i] <= r_res[i-1];
                        r_flg[i] <= r_flg[i-1];
                    end
                end
            end
            if (flush) begin
                r_vld <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cc <= CC_RESET;
        end else if (w_retire && r_set[STAGES-1]) begin
            r_cc <= r_flg[STAGES-1];
        end
    end

    assign out_valid  = r_vld[STAGES-1];
    assign out_result = r_res[STAGES-1];
    assign out_zf     = r_flg[STAGES-1].zf;
    assign out_sf     = r_flg[STAGES-1].sf;
    assign out_of     = r_flg[STAGES-1].of;

    assign cc_zf = r_cc.zf;
    assign cc_sf = r_cc.sf;
    assign cc_of = r_cc.of;
    assign cnd   = cond_eval(r_cc, cond_fn);

endmodule
